// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks in-flight writers in EX/MEM/WB and stalls ID on unforwardable operands.
// Define STALL_PERF_CNT_EN to add the StallCycles performance counter output.
module id_hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int STALL_LIMIT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_RegWrite,
    input  logic [REG_AW-1:0] ID_Dst,
    input  logic              ID_IsLoad,
    input  logic              Flush,
    output logic              Stall,
    output logic              EXMEM_RegisterWrite,
    output logic [REG_AW-1:0] EXMEM_RegisterRd,
    output logic              MEMWB_RegisterWrite,
    output logic [REG_AW-1:0] MEMWB_RegisterRd,
    output logic              StallErr
`ifdef STALL_PERF_CNT_EN
    ,output logic [31:0]      StallCycles
`endif
);
    localparam logic [3:0] LIM = 4'(STALL_LIMIT);
    logic              ex_v, ex_ld, mem_v, mem_ld, wb_v, err, ma, mb, iss;
    logic [REG_AW-1:0] ex_dst, mem_dst, wb_dst;
    logic [3:0]        cnt, cnt_nxt;
    assign ma = ID_Valid & ID_UsesRs & (ID_Rs != '0);
    assign mb = ID_Valid & ID_UsesRt & (ID_Rt != '0);
    // EX producers are never forwardable to ID; MEM producers only when not a load
    assign Stall = ~Flush & ((ma & ex_v & (ex_dst == ID_Rs)) | (mb & ex_v & (ex_dst == ID_Rt)) |
                             (ma & mem_v & mem_ld & (mem_dst == ID_Rs)) |
                             (mb & mem_v & mem_ld & (mem_dst == ID_Rt)));
    assign iss = ID_Valid & ID_RegWrite & (ID_Dst != '0) & ~Flush & ~Stall;
    assign cnt_nxt = Stall ? ((cnt == 4'hF) ? cnt : cnt + 4'd1) : 4'd0;
    assign EXMEM_RegisterWrite = mem_v;
    assign EXMEM_RegisterRd    = mem_dst;
    assign MEMWB_RegisterWrite = wb_v;
    assign MEMWB_RegisterRd    = wb_dst;
    assign StallErr            = err;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_v    <= 1'b0;
            ex_dst  <= '0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_dst <= '0;
            mem_ld  <= 1'b0;
            wb_v    <= 1'b0;
            wb_dst  <= '0;
            cnt     <= 4'd0;
            err     <= 1'b0;
        end else begin
            ex_v    <= iss;
            ex_dst  <= iss ? ID_Dst : '0;
            ex_ld   <= iss & ID_IsLoad;
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
            mem_ld  <= ex_ld;
            wb_v    <= mem_v;
            wb_dst  <= mem_dst;
            cnt     <= cnt_nxt;
            err     <= err | (Stall & (cnt_nxt >= LIM));
        end
    end
`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) StallCycles <= 32'd0;
        else if (Stall) StallCycles <= StallCycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed checks of stall timing, slot outputs and watchdog.
module tb_id_hazard_scoreboard;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ID_Valid = 1'b0, ID_UsesRs = 1'b0, ID_UsesRt = 1'b0;
    logic       ID_RegWrite = 1'b0, ID_IsLoad = 1'b0, Flush = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, ID_Dst = '0;
    logic       Stall, EXMEM_RegisterWrite, MEMWB_RegisterWrite, StallErr;
    logic [4:0] EXMEM_RegisterRd, MEMWB_RegisterRd;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] StallCycles;
`endif
    int errors = 0;
    int checks = 0;

    id_hazard_scoreboard #(.REG_AW(5), .STALL_LIMIT(3)) dut (
        .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite),
        .ID_Dst(ID_Dst), .ID_IsLoad(ID_IsLoad), .Flush(Flush), .Stall(Stall),
        .EXMEM_RegisterWrite(EXMEM_RegisterWrite), .EXMEM_RegisterRd(EXMEM_RegisterRd),
        .MEMWB_RegisterWrite(MEMWB_RegisterWrite), .MEMWB_RegisterRd(MEMWB_RegisterRd),
        .StallErr(StallErr)
`ifdef STALL_PERF_CNT_EN
        , .StallCycles(StallCycles)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic urs, input logic [4:0] rs, input logic urt,
                         input logic [4:0] rt, input logic rw, input logic [4:0] dst,
                         input logic ld, input logic fl);
        ID_Valid = v; ID_UsesRs = urs; ID_Rs = rs; ID_UsesRt = urt; ID_Rt = rt;
        ID_RegWrite = rw; ID_Dst = dst; ID_IsLoad = ld; Flush = fl;
        #1;
    endtask

    initial begin
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_exmem_w", 32'(EXMEM_RegisterWrite), 0);
        chk("rst_exmem_rd", 32'(EXMEM_RegisterRd), 0);
        chk("rst_memwb_w", 32'(MEMWB_RegisterWrite), 0);
        chk("rst_memwb_rd", 32'(MEMWB_RegisterRd), 0);
        chk("rst_err", 32'(StallErr), 0);
        // ALU producer at distance 1
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
        chk("alu_issue_stall", 32'(Stall), 0);
        tick();
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
        chk("alu_stall1", 32'(Stall), 1);
        tick();
        chk("alu_stall_end", 32'(Stall), 0);
        chk("alu_exmem_w", 32'(EXMEM_RegisterWrite), 1);
        chk("alu_exmem_rd", 32'(EXMEM_RegisterRd), 8);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use at distance 1
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0);
        tick();
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0);
        chk("ld_stall1", 32'(Stall), 1);
        tick();
        chk("ld_stall2", 32'(Stall), 1);
        tick();
        chk("ld_stall_end", 32'(Stall), 0);
        chk("ld_memwb_w", 32'(MEMWB_RegisterWrite), 1);
        chk("ld_memwb_rd", 32'(MEMWB_RegisterRd), 9);
        chk("ld_exmem_w", 32'(EXMEM_RegisterWrite), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // writer to $0 is not tracked
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("r0_stall", 32'(Stall), 0);
        chk("r0_exmem_w", 32'(EXMEM_RegisterWrite), 0);
        tick();
        chk("r0_stall2", 32'(Stall), 0);
        chk("r0_exmem_w2", 32'(EXMEM_RegisterWrite), 0);
        chk("r0_memwb_w", 32'(MEMWB_RegisterWrite), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // flush squashes the consumer of a load in EX
        drive(1, 0, 0, 0, 0, 1, 12, 1, 0);
        tick();
        drive(1, 1, 12, 0, 0, 1, 13, 0, 1);
        chk("flush_stall", 32'(Stall), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_exmem_w", 32'(EXMEM_RegisterWrite), 1);
        chk("flush_exmem_rd", 32'(EXMEM_RegisterRd), 12);
        chk("flush_idle_stall", 32'(Stall), 0);
        drive(1, 1, 12, 0, 0, 0, 0, 0, 0);
        chk("ld_dist2_stall", 32'(Stall), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("flush_bubble_ex", 32'(EXMEM_RegisterWrite), 0);
        chk("flush_memwb_rd", 32'(MEMWB_RegisterRd), 12);
        // watchdog with a stuck EX producer
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        force dut.ex_v = 1'b1;
        force dut.ex_dst = 5'd7;
        force dut.ex_ld = 1'b0;
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
        chk("wd_stall", 32'(Stall), 1);
        chk("wd_err0", 32'(StallErr), 0);
        tick();
        chk("wd_err1", 32'(StallErr), 0);
        tick();
        chk("wd_err2", 32'(StallErr), 0);
        tick();
        chk("wd_err3", 32'(StallErr), 1);
`ifdef STALL_PERF_CNT_EN
        chk("wd_cycles", StallCycles, 3);
`endif
        release dut.ex_v;
        release dut.ex_dst;
        release dut.ex_ld;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wd_sticky", 32'(StallErr), 1);
        chk("wd_idle_stall", 32'(Stall), 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("wd_rst_err", 32'(StallErr), 0);
        chk("wd_rst_stall", 32'(Stall), 0);
        chk("wd_rst_exmem_w", 32'(EXMEM_RegisterWrite), 0);
`ifdef STALL_PERF_CNT_EN
        chk("wd_rst_cycles", StallCycles, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Producer-side companion to the ID-stage forwarding unit.
- Tracks every in-flight register write issued from ID through the EX, MEM and WB shadow slots.
- Publishes the EX/MEM and MEM/WB write-enable and destination pairs that the forwarding unit consumes.
- Asserts Stall when an ID-stage source operand cannot yet be forwarded: the producer is still in EX, or is a load still in MEM.

Parameters:
- REG_AW, 5, register-address width.
- STALL_LIMIT, 15, consecutive-stall count at which StallErr asserts (watchdog).

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- ID_Valid  in  1  IF/ID holds a real instruction.
- ID_Rs  in  REG_AW  source register A of the ID instruction.
- ID_Rt  in  REG_AW  source register B of the ID instruction.
- ID_UsesRs  in  1  instruction reads Rs.
- ID_UsesRt  in  1  instruction reads Rt (0 for I-type with Rt as destination).
- ID_RegWrite  in  1  instruction writes a register.
- ID_Dst  in  REG_AW  destination register.
- ID_IsLoad  in  1  result is available only after MEM.
- Flush  in  1  squash the ID instruction (taken branch/jump).
- Stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- EXMEM_RegisterWrite  out  1  MEM slot holds a valid writer.
- EXMEM_RegisterRd  out  REG_AW  MEM slot destination.
- MEMWB_RegisterWrite  out  1  WB slot holds a valid writer.
- MEMWB_RegisterRd  out  REG_AW  WB slot destination.
- StallErr  out  1  sticky watchdog flag.

Behaviour:
- State is three slots, EX/MEM/WB, each holding {v, dst, ld}.
- Reset: all slots v=0, dst=0, ld=0; stall counter 0; StallErr=0. Consequently Stall=0 and all write/Rd outputs are 0.
- Issue qualifier: iss = ID_Valid & ID_RegWrite & (ID_Dst != 0) & ~Flush & ~Stall. A writer to $0 is never tracked.
- Each cycle when not in reset:
  - WB <= MEM; MEM <= EX.
  - EX <= {1, ID_Dst, ID_IsLoad} if iss, else bubble (v=0).
- Matching: mA = ID_Valid & ID_UsesRs & (ID_Rs != 0); mB is the same using Rt.
- Stall (combinational from slot registers and ID inputs) is asserted when either condition holds:
  - (mA & EX.v & EX.dst==ID_Rs) | (mB & EX.v & EX.dst==ID_Rt)
  - (mA & MEM.v & MEM.ld & MEM.dst==ID_Rs) | (mB & MEM.v & MEM.ld & MEM.dst==ID_Rt)
- Flush forces Stall=0. With Flush high the ID instruction is squashed, so no stall and a bubble enters EX.
- No stall is raised for non-load producers in MEM, or for any producer in WB; the forwarding unit covers those cases.
- Output mapping:
  - EXMEM_RegisterWrite=MEM.v and EXMEM_RegisterRd=MEM.dst.
  - MEMWB_RegisterWrite=WB.v and MEMWB_RegisterRd=WB.dst.
  - These are registered, so they change only at the clock edge.
- Latency:
  - ALU-result dependency at distance 1: stalls 1 cycle.
  - Load-use dependency at distance 1: stalls 2 cycles.
  - Load at distance 2: stalls 1 cycle.
- Watchdog:
  - 4-bit counter increments on each cycle Stall=1 and clears on Stall=0.
  - When the counter reaches STALL_LIMIT, StallErr is set and remains set until Reset.
  - The counter saturates at its maximum value.
- Reset asserted mid-stall: all slots cleared on that edge; Stall=0 from the next cycle.

Optional Feature:
- STALL_PERF_CNT_EN defined: adds output StallCycles [31:0].
  - Counts total cycles with Stall=1 since Reset; wraps at 2^32.
  - Reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with ID_Valid=0 -> Stall=0, all write/Rd outputs 0, StallErr=0.
- Issue add $8 (ID_Dst=8, IsLoad=0); next cycle ID reads Rs=8 -> Stall=1 for exactly 1 cycle. The following cycle has EXMEM_RegisterWrite=1, EXMEM_RegisterRd=8, and Stall=0.
- Issue lw $9; next cycle ID reads Rt=9 with UsesRt=1 -> Stall=1 for 2 consecutive cycles. Then MEMWB_RegisterRd=9, MEMWB_RegisterWrite=1, and Stall=0.
- Issue lw $0, then an instruction reading $0 -> Stall=0 throughout; all write outputs remain 0.
- Load producer in EX and consumer in ID with Flush=1 in the same cycle -> Stall=0. The next cycle has a bubble in EX; the load advances to MEM, giving EXMEM_RegisterRd=load dst.
- Hold a matching dependency with a stuck EX producer via forced slot, using STALL_LIMIT=3 -> StallErr=1 on the third stall cycle and stays 1. Reset clears it; with STALL_PERF_CNT_EN defined, StallCycles=3 before the reset.
